// File: rtl/cpu_pkg.sv
// Shared definitions for the multi-cycle core: instruction fields, opcodes and FSM states.
package cpu_pkg;

    localparam int unsigned INSTR_W   = 16;
    localparam int unsigned REG_IDX_W = 3;
    localparam int unsigned OP_W      = 4;
    localparam int unsigned IMM_W     = 6;

    localparam int unsigned OP_LSB  = 12;
    localparam int unsigned RD_LSB  = 9;
    localparam int unsigned RS1_LSB = 6;
    localparam int unsigned RS2_LSB = 3;

    typedef enum logic [OP_W-1:0] {
        OP_NOP  = 4'd0,
        OP_ADD  = 4'd1,
        OP_SUB  = 4'd2,
        OP_AND  = 4'd3,
        OP_OR   = 4'd4,
        OP_ADDI = 4'd5,
        OP_LD   = 4'd6,
        OP_ST   = 4'd7,
        OP_BEQ  = 4'd8,
        OP_JR   = 4'd9,
        OP_HALT = 4'd15
    } opcode_e;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT
    } state_e;

    function automatic logic is_illegal(input logic [OP_W-1:0] op);
        return (op >= 4'd10) && (op <= 4'd14);
    endfunction

    function automatic logic writes_rd(input logic [OP_W-1:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) ||
               (op == OP_OR)  || (op == OP_ADDI) || (op == OP_LD);
    endfunction

endpackage

// File: rtl/cpu_regfile.sv
// 8-entry register file: two asynchronous read ports, one synchronous write port, r0 reads zero.
module cpu_regfile
    import cpu_pkg::*;
#(
    parameter int unsigned DATA_W = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [REG_IDX_W-1:0] raddr1,
    output logic [DATA_W-1:0]    rdata1,
    input  logic [REG_IDX_W-1:0] raddr2,
    output logic [DATA_W-1:0]    rdata2,
    input  logic                 we,
    input  logic [REG_IDX_W-1:0] waddr,
    input  logic [DATA_W-1:0]    wdata
);

    logic [DATA_W-1:0] regs [8];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < 8; i++) begin
                regs[i] <= '0;
            end
        end else if (we && (waddr != '0)) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata1 = (raddr1 == '0) ? '0 : regs[raddr1];
    assign rdata2 = (raddr2 == '0) ? '0 : regs[raddr2];

endmodule

// File: rtl/multicycle_cpu.sv
// Multi-cycle core: FETCH/DECODE/EXEC/MEM/WB/HALT FSM with handshaked instruction and data ports.
module multicycle_cpu
    import cpu_pkg::*;
#(
    parameter int unsigned          DATA_W   = 8,
    parameter int unsigned          ADDR_W   = 8,
    parameter logic [ADDR_W-1:0]    RESET_PC = '0
) (
    input  logic               clk,
    input  logic               reset_n,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               imem_ready,
    output logic               dmem_req,
    output logic               dmem_we,
    output logic [ADDR_W-1:0]  dmem_addr,
    output logic [DATA_W-1:0]  dmem_wdata,
    input  logic [DATA_W-1:0]  dmem_rdata,
    input  logic               dmem_ready,
    output logic               retire,
    output logic               illegal,
    output logic               halted,
    output logic [ADDR_W-1:0]  pc_out
);

    state_e               state;
    logic [ADDR_W-1:0]    pc;
    logic [ADDR_W-1:0]    target;
    logic                 taken;
    logic [INSTR_W-1:0]   instr;
    logic [DATA_W-1:0]    opa;
    logic [DATA_W-1:0]    opb;
    logic [DATA_W-1:0]    result;

    logic [OP_W-1:0]      op;
    logic [REG_IDX_W-1:0] rd;
    logic [REG_IDX_W-1:0] rs1;
    logic [REG_IDX_W-1:0] rs2;
    logic [IMM_W-1:0]     imm;
    logic [DATA_W-1:0]    imm_z;
    logic [DATA_W-1:0]    alu_res;
    logic [ADDR_W-1:0]    br_target;
    logic [ADDR_W-1:0]    next_pc;
    logic [DATA_W-1:0]    rf_rdata1;
    logic [DATA_W-1:0]    rf_rdata2;

    function automatic logic [ADDR_W-1:0] to_addr(input logic [DATA_W-1:0] v);
        logic [ADDR_W+DATA_W-1:0] ext;
        ext = {{ADDR_W{1'b0}}, v};
        return ext[ADDR_W-1:0];
    endfunction

    function automatic logic [ADDR_W-1:0] sext_imm(input logic [IMM_W-1:0] v);
        logic [ADDR_W+IMM_W-1:0] ext;
        ext = {{ADDR_W{v[IMM_W-1]}}, v};
        return ext[ADDR_W-1:0];
    endfunction

    assign op    = instr[OP_LSB +: OP_W];
    assign rd    = instr[RD_LSB +: REG_IDX_W];
    assign rs1   = instr[RS1_LSB +: REG_IDX_W];
    assign rs2   = instr[RS2_LSB +: REG_IDX_W];
    assign imm   = instr[IMM_W-1:0];
    assign imm_z = {{(DATA_W-IMM_W){1'b0}}, imm};

    assign br_target = pc + ADDR_W'(1) + sext_imm(imm);
    assign next_pc   = taken ? target : pc + ADDR_W'(1);
    assign pc_out    = pc;

    always_comb begin
        alu_res = opa + imm_z;
        case (op)
            OP_ADD:  alu_res = opa + opb;
            OP_SUB:  alu_res = opa - opb;
            OP_AND:  alu_res = opa & opb;
            OP_OR:   alu_res = opa | opb;
            default: alu_res = opa + imm_z;
        endcase
    end

    // BEQ compares rd against rs1 and ST stores rd, so port 2 reads rd for those
    cpu_regfile #(.DATA_W(DATA_W)) u_regfile (
        .clk    (clk),
        .reset_n(reset_n),
        .raddr1 (rs1),
        .rdata1 (rf_rdata1),
        .raddr2 (((op == OP_BEQ) || (op == OP_ST)) ? rd : rs2),
        .rdata2 (rf_rdata2),
        .we     ((state == S_WB) && writes_rd(op)),
        .waddr  (rd),
        .wdata  (result)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_FETCH;
            pc         <= RESET_PC;
            target     <= '0;
            taken      <= 1'b0;
            instr      <= '0;
            opa        <= '0;
            opb        <= '0;
            result     <= '0;
            imem_req   <= 1'b0;
            imem_addr  <= '0;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
            retire     <= 1'b0;
            illegal    <= 1'b0;
            halted     <= 1'b0;
        end else begin
            retire  <= 1'b0;
            illegal <= 1'b0;
            case (state)
                S_FETCH: begin
                    if (imem_req && imem_ready) begin
                        instr    <= imem_rdata;
                        imem_req <= 1'b0;
                        state    <= S_DECODE;
                    end else begin
                        imem_req  <= 1'b1;
                        imem_addr <= pc;
                    end
                end
                S_DECODE: begin
                    opa   <= rf_rdata1;
                    opb   <= rf_rdata2;
                    state <= S_EXEC;
                end
                S_EXEC: begin
                    result <= alu_res;
                    target <= (op == OP_JR) ? to_addr(alu_res) : br_target;
                    taken  <= (op == OP_JR) || ((op == OP_BEQ) && (opa == opb));
                    if ((op == OP_LD) || (op == OP_ST)) begin
                        dmem_req   <= 1'b1;
                        dmem_we    <= (op == OP_ST);
                        dmem_addr  <= to_addr(alu_res);
                        dmem_wdata <= opb;
                        state      <= S_MEM;
                    end else begin
                        retire  <= 1'b1;
                        illegal <= is_illegal(op);
                        state   <= S_WB;
                    end
                end
                S_MEM: begin
                    if (dmem_req && dmem_ready) begin
                        result   <= dmem_rdata;
                        dmem_req <= 1'b0;
                        dmem_we  <= 1'b0;
                        retire   <= 1'b1;
                        state    <= S_WB;
                    end
                end
                S_WB: begin
                    if (op == OP_HALT) begin
                        halted <= 1'b1;
                        state  <= S_HALT;
                    end else begin
                        pc        <= next_pc;
                        imem_req  <= 1'b1;
                        imem_addr <= next_pc;
                        state     <= S_FETCH;
                    end
                end
                default: begin
                    state <= S_HALT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_cpu.sv
// Scoreboard bench for multicycle_cpu: directed program, retire and data-port expectations queued, monitor compares.
module tb_multicycle_cpu;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic [15:0] imem_rdata;
    logic        imem_ready;
    logic        dmem_req;
    logic        dmem_we;
    logic [7:0]  dmem_addr;
    logic [7:0]  dmem_wdata;
    logic [7:0]  dmem_rdata;
    logic        dmem_ready;
    logic        retire;
    logic        illegal;
    logic        halted;
    logic [7:0]  pc_out;

    multicycle_cpu #(.DATA_W(8), .ADDR_W(8), .RESET_PC(8'd0)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .imem_req  (imem_req),
        .imem_addr (imem_addr),
        .imem_rdata(imem_rdata),
        .imem_ready(imem_ready),
        .dmem_req  (dmem_req),
        .dmem_we   (dmem_we),
        .dmem_addr (dmem_addr),
        .dmem_wdata(dmem_wdata),
        .dmem_rdata(dmem_rdata),
        .dmem_ready(dmem_ready),
        .retire    (retire),
        .illegal   (illegal),
        .halted    (halted),
        .pc_out    (pc_out)
    );

    always #5 clk = ~clk;

    // memory models with programmable wait states
    logic [15:0] imem [256];
    logic [7:0]  dmem [256];
    int          imem_wait;
    int          dmem_wait;
    int          icnt;
    int          dcnt;

    assign imem_ready = imem_req && (icnt >= imem_wait);
    assign dmem_ready = dmem_req && (dcnt >= dmem_wait);
    assign imem_rdata = imem[imem_addr];
    assign dmem_rdata = dmem[dmem_addr];

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            icnt <= 0;
            dcnt <= 0;
        end else begin
            icnt <= (imem_req && !imem_ready) ? icnt + 1 : 0;
            dcnt <= (dmem_req && !dmem_ready) ? dcnt + 1 : 0;
            if (dmem_req && dmem_ready && dmem_we) dmem[dmem_addr] <= dmem_wdata;
        end
    end

    typedef struct { logic [7:0] pc; logic ill; int cyc; } ret_t;
    typedef struct { logic we; logic [7:0] addr; logic [7:0] wdata; } mem_t;

    ret_t ret_q[$];
    mem_t mem_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] enc(input int op, input int rd, input int rs1, input int low6);
        logic [31:0] o, d, s, l;
        o = op; d = rd; s = rs1; l = low6;
        return {o[3:0], d[2:0], s[2:0], l[5:0]};
    endfunction

    task automatic load_program();
        for (int i = 0; i < 256; i++) imem[i] = enc(5, 7, 0, 1);
        imem[0]  = enc(5, 1, 0, 5);     // ADDI r1,r0,5
        imem[1]  = enc(5, 2, 0, 3);     // ADDI r2,r0,3
        imem[2]  = enc(1, 3, 1, 2*8);   // ADD r3,r1,r2   -> 8
        imem[3]  = enc(2, 4, 2, 1*8);   // SUB r4,r2,r1   -> FE
        imem[4]  = enc(7, 3, 0, 10);    // ST r3,[10]
        imem[5]  = enc(6, 5, 0, 10);    // LD r5,[10]
        imem[6]  = enc(7, 5, 0, 11);    // ST r5,[11]
        imem[7]  = enc(7, 4, 0, 12);    // ST r4,[12]
        imem[8]  = enc(8, 1, 1, 1);     // BEQ r1,r1,+1 -> 10
        imem[10] = enc(8, 1, 2, 4);     // BEQ r1,r2,+4 not taken
        imem[11] = enc(9, 0, 1, 9);     // JR r1,+9 -> 14
        imem[14] = enc(5, 0, 0, 7);     // ADDI r0,r0,7 discarded
        imem[15] = enc(1, 6, 0, 1*8);   // ADD r6,r0,r1 -> 5
        imem[16] = enc(7, 6, 0, 13);    // ST r6,[13]
        imem[17] = enc(12, 7, 1, 1*8);  // illegal
        imem[18] = enc(7, 7, 0, 14);    // ST r7,[14] -> 0
        imem[19] = enc(9, 0, 0, 22);    // JR r0,+22
        imem[21] = enc(8, 0, 0, 3);     // BEQ -> 25
        imem[22] = enc(8, 0, 0, -2);    // BEQ -> 21
        imem[25] = enc(5, 4, 4, 3);     // ADDI r4,r4,3 -> 01 (wrap)
        imem[26] = enc(7, 4, 0, 63);    // ST r4,[63]
        imem[27] = enc(15, 0, 0, 0);    // HALT
    endtask

    task automatic push_program(input int w, input int d);
        logic [7:0] pcs [22] = '{0,1,2,3,4,5,6,7,8,10,11,14,15,16,17,18,19,22,21,25,26,27};
        logic [7:0] madr [7] = '{10, 10, 11, 12, 13, 14, 63};
        logic [7:0] mdat [7] = '{8, 0, 8, 8'hFE, 5, 0, 1};
        ret_t r;
        mem_t m;
        for (int i = 0; i < 22; i++) begin
            logic is_mem;
            is_mem = (pcs[i] inside {4, 5, 6, 7, 16, 18, 26});
            r.pc  = pcs[i];
            r.ill = (pcs[i] == 17);
            r.cyc = (i == 0) ? 0 : (is_mem ? 5 + w + d : 4 + w);
            ret_q.push_back(r);
        end
        for (int i = 0; i < 7; i++) begin
            m.we    = (i != 1);
            m.addr  = madr[i];
            m.wdata = mdat[i];
            mem_q.push_back(m);
        end
    endtask

    task automatic wait_halt();
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (halted) break;
        end
        chk("halt_reached", halted, 1);
    endtask

    // monitor: compares data-port activity and retire events against the queues
    initial begin
        int   cyc = 0;
        int   last_ret = -1;
        ret_t r;
        mem_t m;
        forever begin
            @(negedge clk);
            cyc++;
            if (!reset_n) begin
                last_ret = -1;
            end else begin
                if (dmem_req) begin
                    if (mem_q.size() == 0) begin
                        n_vec++; n_err++;
                        $display("FAIL dmem_unexpected: got addr %0h, expected no access", dmem_addr);
                    end else begin
                        m = mem_q[0];
                        chk("dmem_we", dmem_we, m.we);
                        chk("dmem_addr", dmem_addr, m.addr);
                        if (m.we) chk("dmem_wdata", dmem_wdata, m.wdata);
                        if (dmem_ready) void'(mem_q.pop_front());
                    end
                end
                if (retire) begin
                    if (ret_q.size() == 0) begin
                        n_vec++; n_err++;
                        $display("FAIL retire_unexpected: got pc %0h, expected no retire", pc_out);
                    end else begin
                        r = ret_q.pop_front();
                        chk("retire_pc", pc_out, r.pc);
                        chk("retire_illegal", illegal, r.ill);
                        if (r.cyc > 0 && last_ret >= 0) chk("retire_gap", cyc - last_ret, r.cyc);
                    end
                    last_ret = cyc;
                end else if (illegal) begin
                    n_vec++; n_err++;
                    $display("FAIL illegal_no_retire: got 1 expected 0");
                end
            end
        end
    end

    initial begin
        reset_n   = 1'b0;
        imem_wait = 0;
        dmem_wait = 3;
        load_program();
        for (int i = 0; i < 256; i++) dmem[i] = 8'h55;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_imem_req", imem_req, 0);
        chk("rst_dmem_req", dmem_req, 0);
        chk("rst_halted", halted, 0);
        chk("rst_retire", retire, 0);
        chk("rst_pc", pc_out, 0);
        push_program(0, 3);
        @(negedge clk) reset_n = 1'b1;
        #1 chk("imem_req_before_clk", imem_req, 0);
        @(posedge clk) #1;
        chk("first_fetch_req", imem_req, 1);
        chk("first_fetch_addr", imem_addr, 0);
        wait_halt();
        chk("halt_pc", pc_out, 27);
        chk("ret_q_drained", ret_q.size(), 0);
        chk("mem_q_drained", mem_q.size(), 0);
        for (int i = 0; i < 20; i++) begin
            @(posedge clk) #1;
            chk("halt_quiet", {imem_req, dmem_req, retire, halted}, 4'b0001);
        end

        // second pass: reset asserted asynchronously while a store is waiting
        @(negedge clk) reset_n = 1'b0;
        imem_wait = 1;
        dmem_wait = 2;
        for (int i = 0; i < 256; i++) dmem[i] = 8'h55;
        push_program(1, 2);
        @(negedge clk) reset_n = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (dmem_req) break;
        end
        chk("mid_mem_reached", dmem_req, 1);
        @(posedge clk) #2;
        reset_n = 1'b0;
        #1;
        chk("async_dmem_req", dmem_req, 0);
        chk("async_dmem_we", dmem_we, 0);
        chk("async_dmem_addr", dmem_addr, 0);
        chk("async_dmem_wdata", dmem_wdata, 0);
        chk("async_imem_req", imem_req, 0);
        chk("async_pc", pc_out, 0);
        ret_q.delete();
        mem_q.delete();
        for (int i = 0; i < 256; i++) dmem[i] = 8'h55;
        push_program(1, 2);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk) #1;
        chk("refetch_req", imem_req, 1);
        chk("refetch_addr", imem_addr, 0);
        wait_halt();
        chk("halt_pc_2", pc_out, 27);
        chk("ret_q_drained_2", ret_q.size(), 0);
        chk("mem_q_drained_2", mem_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
